lsu_mem_initiator: RTL and testbench

Load/store initiator between the RISC-V pipeline's memory stage and the data-memory controller. It accepts one load or store request at a time and stalls the pipeline while the request is outstanding. It issues a single-cycle read or write enable with func3, address and store data to the controller, waits for the controller's ready handshake, and returns the load data. It also flags illegal func3 codes and responder timeouts.

---
 rtl/lsu_mem_initiator.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: issues one read or write to the data-memory controller,
// stalls the pipeline until the controller completes, and returns load data.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; latch it, check func3, wait mem_ready
//   ISSUE | one-cycle read/write enable to the controller
//   WAIT  | wait for busy-then-ready from controller, or timeout
//   DONE  | one-cycle completion pulse (done/load_valid/err)
module lsu_mem_initiator #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     req_valid,
   input  logic                     req_is_store,
   input  logic [2:0]               req_func3,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0]    req_store_data,
   output logic                     stall,
   output logic                     done,
   output logic                     load_valid,
   output logic [DATA_WIDTH-1:0]    load_data,
   output logic                     err,
   output logic                     mem_read_En,
   output logic                     mem_write_En,
   output logic [2:0]               mem_func3,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_data_out,
   input  logic [DATA_WIDTH-1:0]    mem_data_in,
   input  logic                     mem_ready
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic             is_store_q;
   logic             seen_busy;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             req_legal;

   always_comb begin
      req_legal = 1'b0;
      case (req_func3)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = ~req_is_store;
         default:                req_legal = 1'b0;
      endcase
   end

   // Saturating increment so a stuck responder can never wrap the counter.
   always_comb begin
      wait_cnt_inc = wait_cnt;
      if (wait_cnt != CNT_MAX) wait_cnt_inc = wait_cnt + CNT_W'(1);
   end

   assign stall = ((state == S_IDLE) && req_valid) || (state == S_ISSUE) || (state == S_WAIT);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state        <= S_IDLE;
         is_store_q   <= 1'b0;
         seen_busy    <= 1'b0;
         wait_cnt     <= '0;
         done         <= 1'b0;
         load_valid   <= 1'b0;
         err          <= 1'b0;
         load_data    <= '0;
         mem_read_En  <= 1'b0;
         mem_write_En <= 1'b0;
         mem_func3    <= '0;
         mem_address  <= '0;
         mem_data_out <= '0;
      end else begin
         done         <= 1'b0;
         load_valid   <= 1'b0;
         err          <= 1'b0;
         mem_read_En  <= 1'b0;
         mem_write_En <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  mem_func3    <= req_func3;
                  mem_address  <= req_address;
                  mem_data_out <= req_store_data;
                  is_store_q   <= req_is_store;
                  if (!req_legal) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (mem_ready) begin
                     state        <= S_ISSUE;
                     mem_read_En  <= ~req_is_store;
                     mem_write_En <= req_is_store;
                  end
               end
            end
            S_ISSUE: begin
               seen_busy <= 1'b0;
               wait_cnt  <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (!mem_ready) seen_busy <= 1'b1;
               wait_cnt <= wait_cnt_inc;
               // Ready before any busy cycle is the controller's idle state, not completion.
               if (mem_ready && seen_busy) begin
                  state      <= S_DONE;
                  done       <= 1'b1;
                  load_valid <= ~is_store_q;
                  if (!is_store_q) load_data <= mem_data_in;
               end else if (wait_cnt_inc == CNT_MAX) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  err       <= 1'b1;
                  load_data <= '0;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a small scripted memory responder.
module tb_lsu_mem_initiator;

   logic        clk;
   logic        rstN;
   logic        req_valid;
   logic        req_is_store;
   logic [2:0]  req_func3;
   logic [31:0] req_address;
   logic [31:0] req_store_data;
   logic        stall;
   logic        done;
   logic        load_valid;
   logic [31:0] load_data;
   logic        err;
   logic        mem_read_En;
   logic        mem_write_En;
   logic [2:0]  mem_func3;
   logic [31:0] mem_address;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in;
   logic        mem_ready;

   int n_vec = 0;
   int n_miscmp = 0;

   // responder script
   int          hold_low = 0;
   int          pre_left = 0;
   int          busy_left = 0;
   int          cfg_pre = 0;
   int          cfg_n = 0;
   logic [31:0] cfg_data = '0;

   lsu_mem_initiator #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk           (clk),
      .rstN          (rstN),
      .req_valid     (req_valid),
      .req_is_store  (req_is_store),
      .req_func3     (req_func3),
      .req_address   (req_address),
      .req_store_data(req_store_data),
      .stall         (stall),
      .done          (done),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .err           (err),
      .mem_read_En   (mem_read_En),
      .mem_write_En  (mem_write_En),
      .mem_func3     (mem_func3),
      .mem_address   (mem_address),
      .mem_data_out  (mem_data_out),
      .mem_data_in   (mem_data_in),
      .mem_ready     (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge and update the responder for that cycle.
   task automatic step();
      @(posedge clk);
      #1;
      mem_data_in = cfg_data;
      if (hold_low > 0) begin
         mem_ready = 1'b0;
         hold_low--;
      end else if (mem_read_En || mem_write_En) begin
         mem_ready = 1'b1;
         pre_left  = cfg_pre;
         busy_left = cfg_n;
      end else if (pre_left > 0) begin
         mem_ready = 1'b1;
         pre_left--;
      end else if (busy_left > 0) begin
         mem_ready = 1'b0;
         busy_left--;
      end else begin
         mem_ready = 1'b1;
      end
   endtask

   task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int hold, input int pre, input int n, input logic [31:0] rdata,
                          input int issue_cyc, input int done_cyc,
                          input logic exp_err, input logic [31:0] exp_ld);
      cfg_pre        = pre;
      cfg_n          = n;
      cfg_data       = rdata;
      mem_data_in    = rdata;
      req_is_store   = st;
      req_func3      = f3;
      req_address    = addr;
      req_store_data = sdata;
      for (int c = 0; c <= done_cyc + 1; c++) begin
         if (c > 0) step();
         if (c == 0 && hold > 0) begin
            mem_ready = 1'b0;
            hold_low  = hold - 1;
         end
         // held through DONE as the retiring request, which must be ignored
         req_valid = (c <= done_cyc);
         #3;
         check_val($sformatf("%s c%0d stall", tag, c), 32'(stall), 32'(c < done_cyc));
         check_val($sformatf("%s c%0d rd_en", tag, c), 32'(mem_read_En), 32'(c == issue_cyc && !st));
         check_val($sformatf("%s c%0d wr_en", tag, c), 32'(mem_write_En), 32'(c == issue_cyc && st));
         check_val($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == done_cyc));
         check_val($sformatf("%s c%0d load_valid", tag, c), 32'(load_valid),
                   32'(c == done_cyc && !st && !exp_err));
         if (c == done_cyc) begin
            check_val($sformatf("%s err", tag), 32'(err), 32'(exp_err));
            check_val($sformatf("%s load_data", tag), load_data, exp_ld);
            check_val($sformatf("%s mem_func3", tag), 32'(mem_func3), 32'(f3));
            check_val($sformatf("%s mem_address", tag), mem_address, addr);
            check_val($sformatf("%s mem_data_out", tag), mem_data_out, sdata);
         end
      end
      req_valid = 1'b0;
      busy_left = 0;
      step();
   endtask

   initial begin
      rstN           = 1'b0;
      req_valid      = 1'b0;
      req_is_store   = 1'b0;
      req_func3      = '0;
      req_address    = '0;
      req_store_data = '0;
      mem_data_in    = '0;
      mem_ready      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst stall", 32'(stall), 32'h0);
      check_val("rst done", 32'(done), 32'h0);
      check_val("rst err", 32'(err), 32'h0);
      check_val("rst rd_en", 32'(mem_read_En), 32'h0);
      check_val("rst wr_en", 32'(mem_write_En), 32'h0);
      check_val("rst mem_address", mem_address, 32'h0);
      check_val("rst load_data", load_data, 32'h0);
      rstN = 1'b1;
      step();

      //      tag        st  f3      addr    sdata        hold pre n     rdata         iss dn  err  exp_ld
      run_txn("lw",      0, 3'b010, 32'h10, 32'h0,        0,  0,  4,    32'hDEADBEEF, 1,  7, 1'b0, 32'hDEADBEEF);
      run_txn("sb",      1, 3'b000, 32'h20, 32'hAB,       0,  0,  1,    32'h55555555, 1,  4, 1'b0, 32'hDEADBEEF);
      run_txn("ill_ld",  0, 3'b011, 32'h30, 32'h0,        0,  0,  1,    32'h0,       -1,  1, 1'b1, 32'hDEADBEEF);
      run_txn("ill_st",  1, 3'b100, 32'h34, 32'h77,       0,  0,  1,    32'h0,       -1,  1, 1'b1, 32'hDEADBEEF);
      run_txn("lh_hold", 0, 3'b001, 32'h44, 32'h0,        3,  2,  1,    32'hFFFF8001, 4,  9, 1'b0, 32'hFFFF8001);
      run_txn("lw_tmo",  0, 3'b010, 32'h50, 32'h0,        0,  0,  1000, 32'hCAFEF00D, 1, 10, 1'b1, 32'h0);
      run_txn("lhu",     0, 3'b101, 32'h54, 32'h0,        0,  0,  2,    32'h0000BEEF, 1,  5, 1'b0, 32'h0000BEEF);

      // Reset while the initiator sits in WAIT.
      cfg_pre     = 0;
      cfg_n       = 100;
      cfg_data    = 32'h99999999;
      req_is_store = 1'b0;
      req_func3   = 3'b010;
      req_address = 32'h40;
      req_valid   = 1'b1;
      step();
      step();
      step();
      #2;
      rstN      = 1'b0;
      req_valid = 1'b0;
      #1;
      check_val("rstw stall", 32'(stall), 32'h0);
      check_val("rstw done", 32'(done), 32'h0);
      check_val("rstw rd_en", 32'(mem_read_En), 32'h0);
      check_val("rstw mem_address", mem_address, 32'h0);
      check_val("rstw mem_func3", 32'(mem_func3), 32'h0);
      check_val("rstw load_data", load_data, 32'h0);
      busy_left = 0;
      mem_ready = 1'b1;
      step();
      check_val("rstw done held", 32'(done), 32'h0);
      rstN = 1'b1;
      step();
      check_val("rstw done after", 32'(done), 32'h0);
      check_val("rstw stall after", 32'(stall), 32'h0);

      run_txn("b2b_lw",  0, 3'b010, 32'h60, 32'h0,        0,  0,  1,    32'h11223344, 1,  4, 1'b0, 32'h11223344);
      run_txn("b2b_sw",  1, 3'b010, 32'h64, 32'hA5A5A5A5, 0,  0,  3,    32'h0,        1,  6, 1'b0, 32'h11223344);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
